fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, 32'h0000_0000: instruction word inserted into IF/ID as a bubble.
REQ-003 Parameter CNT_W, 16: width of the stall and flush performance counters.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 Stall  input  1  load-use stall from the hazard unit; holds PC and IF/ID.
REQ-007 ID_PCSrc  input  2  redirect select: 00 PC+4, 01 branch, 10 jump, 11 jump-register.
REQ-008 BranchTaken  input  1  ID-stage branch-condition result; qualifies ID_PCSrc==01.
REQ-009 BranchTarget  input  32  branch target from ID.
REQ-010 JumpTarget  input  32  J/JAL target from ID.
REQ-011 JrTarget  input  32  register target for JR/JALR from ID.
REQ-012 Instr  input  32  instruction-memory read data for address PC (combinational ROM).
REQ-013 PC  output  32  current fetch address to instruction memory.
REQ-014 IF_ID_Instr  output  32  instruction held in the IF/ID register.
REQ-015 IF_ID_PCPlus4  output  32  PC+4 of the held instruction.
REQ-016 IF_ID_Valid  output  1  1 = real instruction, 0 = bubble.
REQ-017 StallCount  output  CNT_W  saturating count of stalled cycles.
REQ-018 FlushCount  output  CNT_W  saturating count of flushes inserted.

Function
REQ-019 Redirect SHALL be active when (ID_PCSrc==01 && BranchTaken) || ID_PCSrc==10 || ID_PCSrc==11.
REQ-020 The next PC SHALL be BranchTarget, JumpTarget or JrTarget for redirect codes 01/10/11, else PC+4 (32-bit modulo, 32'hFFFF_FFFC wraps to 0).
REQ-021 ID_PCSrc==01 with BranchTaken==0 SHALL behave as 00.
REQ-022 When Stall==1, PC, IF_ID_Instr, IF_ID_PCPlus4 and IF_ID_Valid SHALL hold their values, and any redirect SHALL be ignored that cycle.
REQ-023 When Stall==0 and redirect is active, PC SHALL load the target and IF/ID SHALL load NOP_INSTR, PC+4 of the squashed fetch, and Valid=0 (one-cycle flush).
REQ-024 When Stall==0 and no redirect, PC SHALL load PC+4 and IF/ID SHALL load Instr, PC+4, and Valid=1.
REQ-025 Redirect latency SHALL be 1 cycle: the target appears on PC the edge after redirect is sampled.
REQ-026 The first instruction SHALL enter IF/ID one edge after reset release, with no extra startup bubble.
REQ-027 StallCount SHALL increment on each edge with Stall==1 and saturate at all-ones.
REQ-028 FlushCount SHALL increment on each edge with Stall==0 and redirect active and saturate at all-ones.
REQ-029 Targets SHALL be used unmodified, with no alignment check; low bits pass through.
REQ-030 Internal state SHALL be limited to the PC register, the IF/ID register and the two counters; there is no FSM beyond run, stall and flush.

Reset
REQ-031 Asserting reset low SHALL immediately set PC=RESET_PC, IF_ID_Instr=NOP_INSTR, IF_ID_PCPlus4=0, IF_ID_Valid=0, and both counters=0, regardless of clk.
REQ-032 Reset asserted mid-stall or mid-redirect SHALL discard the pending update, and on release fetch SHALL resume at RESET_PC.
REQ-033 Inputs SHALL be ignored while reset is low.

Verification
REQ-034 Sequential run: release reset, Stall=0, PCSrc=00, Instr=mem[PC] -> PC 0,4,8,C; IF/ID holds mem[0],mem[4] with Valid=1 and PCPlus4 4,8.
REQ-035 Load-use stall: Stall=1 for 2 cycles at PC=8 -> PC stays 8, IF/ID unchanged, StallCount=2, then normal advance resumes.
REQ-036 Taken branch: PCSrc=01, BranchTaken=1, BranchTarget=0x40 at PC=0x10 -> next PC=0x40, IF/ID=NOP with Valid=0, FlushCount=1; PCSrc=01 with BranchTaken=0 -> PC=0x14 and no flush.
REQ-037 Stall plus redirect same cycle: Stall=1, PCSrc=11, JrTarget=0x100 -> PC holds; next cycle Stall=0 with the same inputs -> PC=0x100 and flush.
REQ-038 Saturation and wrap: CNT_W=2 with Stall held 5 cycles -> StallCount=3; PC=0xFFFF_FFFC with PCSrc=00 -> PC=0.
REQ-039 Async reset: assert reset low between clock edges during a redirect -> outputs reach reset values before the next edge, and after release PC=RESET_PC.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage boundary signals: hazard-unit stall, ID-stage redirect
// controls and targets, instruction-memory read path, and the IF/ID
// register plus performance counters presented back to the pipeline.
interface fetch_stage_if #(
  parameter int CNT_W = 16
);
  logic             Stall;
  logic [1:0]       ID_PCSrc;
  logic             BranchTaken;
  logic [31:0]      BranchTarget;
  logic [31:0]      JumpTarget;
  logic [31:0]      JrTarget;
  logic [31:0]      Instr;
  logic [31:0]      PC;
  logic [31:0]      IF_ID_Instr;
  logic [31:0]      IF_ID_PCPlus4;
  logic             IF_ID_Valid;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  // Pipeline/memory side: drives controls and fetched data, observes fetch state.
  modport master (
    output Stall, ID_PCSrc, BranchTaken, BranchTarget, JumpTarget, JrTarget, Instr,
    input  PC, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, StallCount, FlushCount
  );

  // Fetch stage side.
  modport slave (
    input  Stall, ID_PCSrc, BranchTaken, BranchTarget, JumpTarget, JrTarget, Instr,
    output PC, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, StallCount, FlushCount
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and
// saturating stall/flush counters. Each cycle is one of three modes:
// stall (hold everything), flush (redirect PC, insert a bubble) or
// run (sequential fetch).
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.slave  bus
);

  localparam logic [1:0] SRC_SEQ    = 2'b00;
  localparam logic [1:0] SRC_BRANCH = 2'b01;
  localparam logic [1:0] SRC_JUMP   = 2'b10;
  localparam logic [1:0] SRC_JR     = 2'b11;

  // Cycle mode; purely combinational, there is no sequencing state.
  typedef enum logic [1:0] {
    MODE_RUN   = 2'b00,
    MODE_STALL = 2'b01,
    MODE_FLUSH = 2'b10
  } mode_e;

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      if_id_instr_q, if_id_instr_d;
  logic [31:0]      if_id_pcplus4_q, if_id_pcplus4_d;
  logic             if_id_valid_q, if_id_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic             redirect;
  logic [31:0]      pc_plus4;
  logic [31:0]      redirect_target;
  mode_e            mode;

  // Decode the redirect request and pick its target; a not-taken branch
  // falls back to sequential fetch.
  always_comb begin
    redirect        = 1'b0;
    redirect_target = bus.BranchTarget;
    pc_plus4        = pc_q + 32'd4;
    case (bus.ID_PCSrc)
      SRC_BRANCH: begin
        redirect        = bus.BranchTaken;
        redirect_target = bus.BranchTarget;
      end
      SRC_JUMP: begin
        redirect        = 1'b1;
        redirect_target = bus.JumpTarget;
      end
      SRC_JR: begin
        redirect        = 1'b1;
        redirect_target = bus.JrTarget;
      end
      default: begin
        redirect        = 1'b0;
        redirect_target = pc_plus4;
      end
    endcase

    if (bus.Stall) begin
      mode = MODE_STALL;
    end else if (redirect) begin
      mode = MODE_FLUSH;
    end else begin
      mode = MODE_RUN;
    end
  end

  // Next-state for PC, IF/ID and counters; stall holds, so it only
  // touches the stall counter.
  always_comb begin
    pc_d            = pc_q;
    if_id_instr_d   = if_id_instr_q;
    if_id_pcplus4_d = if_id_pcplus4_q;
    if_id_valid_d   = if_id_valid_q;
    stall_cnt_d     = stall_cnt_q;
    flush_cnt_d     = flush_cnt_q;

    case (mode)
      MODE_STALL: begin
        if (stall_cnt_q != {CNT_W{1'b1}}) begin
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
      end
      MODE_FLUSH: begin
        // The instruction fetched this cycle is on the wrong path: squash
        // it but keep its PC+4 so the bubble still carries an address.
        pc_d            = redirect_target;
        if_id_instr_d   = NOP_INSTR;
        if_id_pcplus4_d = pc_plus4;
        if_id_valid_d   = 1'b0;
        if (flush_cnt_q != {CNT_W{1'b1}}) begin
          flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        pc_d            = pc_plus4;
        if_id_instr_d   = bus.Instr;
        if_id_pcplus4_d = pc_plus4;
        if_id_valid_d   = 1'b1;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q            <= RESET_PC;
      if_id_instr_q   <= NOP_INSTR;
      if_id_pcplus4_q <= 32'h0000_0000;
      if_id_valid_q   <= 1'b0;
      stall_cnt_q     <= '0;
      flush_cnt_q     <= '0;
    end else begin
      pc_q            <= pc_d;
      if_id_instr_q   <= if_id_instr_d;
      if_id_pcplus4_q <= if_id_pcplus4_d;
      if_id_valid_q   <= if_id_valid_d;
      stall_cnt_q     <= stall_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
    end
  end

  assign bus.PC            = pc_q;
  assign bus.IF_ID_Instr   = if_id_instr_q;
  assign bus.IF_ID_PCPlus4 = if_id_pcplus4_q;
  assign bus.IF_ID_Valid   = if_id_valid_q;
  assign bus.StallCount    = stall_cnt_q;
  assign bus.FlushCount    = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by
// random stall/redirect traffic, compared against a cycle-level model
// that applies the fetch rules directly. A second instance with 2-bit
// counters receives identical stimulus to exercise saturation.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst_n;

  fetch_stage_if #(.CNT_W(16)) bif ();
  fetch_stage_if #(.CNT_W(2))  sbif ();

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP), .CNT_W(16)) dut (
    .clk(clk), .reset(rst_n), .bus(bif.slave)
  );
  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(rst_n), .bus(sbif.slave)
  );

  // Combinational instruction ROM: a fixed scramble of the address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Stimulus shared by both instances.
  logic        in_stall;
  logic [1:0]  in_src;
  logic        in_taken;
  logic [31:0] in_bt, in_jt, in_jrt;

  assign bif.Stall         = in_stall;
  assign bif.ID_PCSrc      = in_src;
  assign bif.BranchTaken   = in_taken;
  assign bif.BranchTarget  = in_bt;
  assign bif.JumpTarget    = in_jt;
  assign bif.JrTarget      = in_jrt;
  assign bif.Instr         = rom(bif.PC);
  assign sbif.Stall        = in_stall;
  assign sbif.ID_PCSrc     = in_src;
  assign sbif.BranchTaken  = in_taken;
  assign sbif.BranchTarget = in_bt;
  assign sbif.JumpTarget   = in_jt;
  assign sbif.JrTarget     = in_jrt;
  assign sbif.Instr        = rom(sbif.PC);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: architectural values plus unbounded event counts.
  logic [31:0] m_pc, m_instr, m_pp4;
  logic        m_valid;
  int          m_stalls, m_flushes;

  function automatic logic [31:0] sat(input int n, input int max);
    return (n > max) ? 32'(max) : 32'(n);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_pp4 = 32'h0; m_valid = 1'b0;
    m_stalls = 0; m_flushes = 0;
  endtask

  task automatic model_step();
    logic        taken_redirect;
    logic [31:0] tgt;
    taken_redirect = 1'b0;
    tgt = 32'h0;
    if (in_src == 2'd1 && in_taken) begin taken_redirect = 1'b1; tgt = in_bt;  end
    if (in_src == 2'd2)             begin taken_redirect = 1'b1; tgt = in_jt;  end
    if (in_src == 2'd3)             begin taken_redirect = 1'b1; tgt = in_jrt; end
    if (in_stall) begin
      m_stalls++;
    end else if (taken_redirect) begin
      m_instr = NOP; m_pp4 = m_pc + 32'd4; m_valid = 1'b0; m_pc = tgt;
      m_flushes++;
    end else begin
      m_instr = rom(m_pc); m_pp4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},     bif.PC,                   m_pc);
    check({tag, ".instr"},  bif.IF_ID_Instr,          m_instr);
    check({tag, ".pp4"},    bif.IF_ID_PCPlus4,        m_pp4);
    check({tag, ".valid"},  32'(bif.IF_ID_Valid),     32'(m_valid));
    check({tag, ".scnt"},   32'(bif.StallCount),      sat(m_stalls, 65535));
    check({tag, ".fcnt"},   32'(bif.FlushCount),      sat(m_flushes, 65535));
    check({tag, ".pc2"},    sbif.PC,                  m_pc);
    check({tag, ".scnt2"},  32'(sbif.StallCount),     sat(m_stalls, 3));
    check({tag, ".fcnt2"},  32'(sbif.FlushCount),     sat(m_flushes, 3));
  endtask

  task automatic set_in(input logic st, input logic [1:0] src, input logic tk,
                        input logic [31:0] bt, input logic [31:0] jt, input logic [31:0] jrt);
    in_stall = st; in_src = src; in_taken = tk; in_bt = bt; in_jt = jt; in_jrt = jrt;
  endtask

  // One clock: model advances with the edge, outputs checked at the falling edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
    $display("cycle %-6s st=%0d src=%0d tk=%0d pc=%h ifid=%h/%h v=%0d sc=%0d fc=%0d",
             tag, in_stall, in_src, in_taken, bif.PC, bif.IF_ID_Instr,
             bif.IF_ID_PCPlus4, bif.IF_ID_Valid, bif.StallCount, bif.FlushCount);
  endtask

  initial begin
    set_in(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    rst_n = 1'b0;
    model_reset();
    #12;
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("rel");

    // Sequential run: 0,4,8.
    cycle("seq");
    cycle("seq");

    // Two-cycle load-use stall at PC=8 with a redirect that must be ignored.
    set_in(1'b1, 2'd2, 1'b0, 32'h0, 32'h0000_0800, 32'h0);
    cycle("stall");
    cycle("stall");
    check("stall.cnt2", 32'(bif.StallCount), 32'd2);
    set_in(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    cycle("seq");
    cycle("seq");
    check("at10", bif.PC, 32'h10);

    // Taken branch at 0x10, then a not-taken branch.
    set_in(1'b0, 2'd1, 1'b1, 32'h40, 32'h0, 32'h0);
    cycle("brT");
    check("brT.pc", bif.PC, 32'h40);
    set_in(1'b0, 2'd1, 1'b0, 32'h80, 32'h0, 32'h0);
    cycle("brN");

    // Stall and JR in the same cycle, then the JR alone.
    set_in(1'b1, 2'd3, 1'b0, 32'h0, 32'h0, 32'h100);
    cycle("stJR");
    set_in(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 32'h100);
    cycle("JR");
    check("JR.pc", bif.PC, 32'h100);

    // Counter saturation on the narrow instance.
    set_in(1'b1, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    repeat (5) cycle("sat");
    check("sat.scnt2", 32'(sbif.StallCount), 32'd3);

    // Wrap: jump to the last word (unaligned-safe target), then fall through to 0.
    set_in(1'b0, 2'd2, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'h0);
    cycle("jtop");
    set_in(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    cycle("wrap");
    check("wrap.pc", bif.PC, 32'h0);

    // Unaligned targets pass through untouched.
    set_in(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 32'h0000_0123);
    cycle("unal");

    // Asynchronous reset between edges while a redirect is pending.
    set_in(1'b0, 2'd2, 1'b0, 32'h0, 32'h0000_0700, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    @(posedge clk);
    @(negedge clk);
    check_all("arsth");
    rst_n = 1'b1;
    #1;
    check_all("arel");
    set_in(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    cycle("post");

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      in_stall = ($urandom_range(0, 3) == 0);
      in_src   = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
      in_taken = 1'($urandom_range(0, 1));
      in_bt    = $urandom;
      in_jt    = $urandom;
      in_jrt   = $urandom;
      cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
